seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for the Basys3 4-digit common-anode 7-segment display. Shares the single segment bus between the four digits. Shows a 32-bit debug value (e.g. register x31) one 16-bit halfword at a time, as 4 hex digits, with frame-coherent updates and anti-ghosting guard slots. Sits in the FPGA top level beside the core, on the 100 MHz board clock.

Parameters:
DIGIT_CYCLES, 100_000, clk cycles per digit slot (1 ms at 100 MHz); must be >= 2
GUARD_CYCLES, 100, leading cycles of each slot with all anodes off; 1 <= GUARD_CYCLES < DIGIT_CYCLES
PAGE_SCANS, 1000, full 4-digit scans per page in auto-alternate mode; must be >= 1

Ports:
clk  in  1  board clock
rst  in  1  reset: synchronous, active-high
value_i  in  32  value to display
value_valid_i  in  1  capture strobe for value_i
page_mode_i  in  2  00 low halfword, 01 high halfword, 10 auto-alternate, 11 treated as 00
blank_i  in  1  force all digits off
seg_o  out  7  segments, active-low, seg_o[0]=a … seg_o[6]=g
an_o  out  4  anodes, active-low, an_o[0]=rightmost digit
page_o  out  1  halfword shown: 0 low, 1 high
scan_tick_o  out  1  one-cycle pulse at each slot start

Behaviour:
- Reset values: all outputs registered. seg_o=7'h7F, an_o=4'hF, page_o=0, scan_tick_o=0. Pending and display registers 0, digit index 0, counters 0. State GUARD.
- Slot counter runs 0..DIGIT_CYCLES-1, then wraps. A slot starts at count 0: scan_tick_o=1 for that cycle; digit index advances 0→1→2→3→0.
- FSM: GUARD for slot counts 0..GUARD_CYCLES-1, with an_o=4'hF and seg_o already showing the current digit's pattern. DRIVE for the remaining counts, with an_o one-cold on the current digit. The first slot after reset is digit 0, and its GUARD starts on the first cycle after rst falls.
- Digit n shows nibble n of the selected halfword of the display register. Hex decode is the standard 0-F pattern, e.g. 0=7'b1000000, 1=7'b1111001, F=7'b0001110.
- value_valid_i: value_i is captured into the pending register on any cycle.
- Frame start is the first cycle of a digit-0 slot. There, the display register loads pending. If value_valid_i is high in that same cycle, the display register loads value_i directly.
- No tearing: a change to value_i mid-frame never alters digits of the frame in progress.
- Page select is evaluated at frame start only.
  - Mode 00/11: page 0. Mode 01: page 1.
  - Mode 10: page toggles when PAGE_SCANS complete frames have elapsed on the current page.
  - The scan counter clears on any page_mode_i change, and on entry to mode 10 page starts at 0.
- blank_i: registered, one-cycle latency. Forces an_o=4'hF. Scanning, counters and captures continue unaffected.
- Reset mid-operation: rst at any edge returns every register to its reset value at that edge. rst has priority over value_valid_i.

Optional Feature:
SEG7_LZB_EN: leading-zero blanking.
- Defined: within the selected halfword, digits above the most significant nonzero nibble keep their anode high during DRIVE. Digit 0 is always driven, so 0x0000 shows a single "0".
- Undefined: all four digits are always driven.

Decomposition:
- seg7_pkg holds:
  - page_mode_e enum (PAGE_LO, PAGE_HI, PAGE_AUTO)
  - scan_state_e enum (GUARD, DRIVE)
  - SEG7_HEX constant array of 16×7-bit active-low patterns
  - SEG_OFF=7'h7F and AN_OFF=4'hF constants
- One sub-module, seg7_hex_decoder: combinational 4-bit nibble to 7-bit active-low segments, using SEG7_HEX.

Test Plan:
1. DIGIT_CYCLES=8, GUARD_CYCLES=2, mode 00, valid value_i=32'h0000_1234. Over the next frame an_o cycles 1110/1101/1011/0111, each driven for 6 cycles after 2 cycles of 1111. seg_o is 0011001 ("4"), 0110000 ("3"), 0100100 ("2"), 1111001 ("1"). scan_tick_o pulses every 8 cycles.
2. Mode 10, PAGE_SCANS=2, value 32'hABCD_1234. page_o=0 for 2 frames (64 cycles) showing 4,3,2,1, then page_o=1 showing D,C,B,A, then back to 0 after 64 more cycles.
3. Tearing: value 0x1111 displayed; pulse valid with 0x5555 during digit 2's slot. Digits 2 and 3 still show "1". All digits show "5" from the next frame start. valid asserted exactly at frame start takes effect in that same frame.
4. blank_i held for 20 cycles mid-scan: an_o=4'hF from the following cycle; on release, scanning resumes on the correct digit with no phase shift. rst pulsed during digit 2's DRIVE: outputs read 7'h7F/4'hF/0 at the next edge, and the next frame shows 0x0000.
5. Value 0x0000_0012. With SEG7_LZB_EN, an_o[3:2] stay 1 throughout and digits 1,0 show "1","2". Without the macro, digits 3,2 show "0" (1000000).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the Basys3 7-segment scan controller.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

  typedef enum logic [1:0] {
    PAGE_LO   = 2'b00,
    PAGE_HI   = 2'b01,
    PAGE_AUTO = 2'b10
  } page_mode_e;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_HEX[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller: shows one 16-bit halfword of a 32-bit value
// with frame-coherent updates and guard slots. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int GUARD_CYCLES = 100,
  parameter int PAGE_SCANS   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        value_valid_i,
  input  logic [1:0]  page_mode_i,
  input  logic        blank_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o,
  output logic        page_o,
  output logic        scan_tick_o
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam int SCN_W = $clog2(PAGE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
  localparam logic [SCN_W-1:0] SCN_LAST  = SCN_W'(PAGE_SCANS);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_digit;
  logic [31:0]      r_pending;
  logic [31:0]      r_display;
  logic             r_page;
  logic [SCN_W-1:0] r_scan_cnt;
  logic [1:0]       r_mode_q;
  scan_state_e      r_state;

  logic             w_frame_start;
  logic             w_cnt_wrap;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_mode_chg;
  logic             w_fresh;
  logic [31:0]      w_frame_value;
  logic [31:0]      w_disp_sel;
  logic             w_page_next;
  logic [SCN_W-1:0] w_scan_next;
  logic [15:0]      w_half;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic             w_digit_en;
  scan_state_e      w_state_next;
  logic [3:0]       w_an_next;

  assign w_frame_start = (r_cnt == '0) && (r_digit == 2'd0);
  assign w_cnt_wrap    = (r_cnt == CNT_LAST);
  assign w_cnt_next    = w_cnt_wrap ? '0 : r_cnt + 1'b1;
  assign w_mode_chg    = (page_mode_i != r_mode_q);
  assign w_fresh       = w_mode_chg || (r_scan_cnt == '0);
  assign w_frame_value = value_valid_i ? value_i : r_pending;

  // NOTE: every variable gets a default first so no path through always_comb infers a latch.
  always_comb begin
    w_page_next = r_page;
    w_scan_next = w_mode_chg ? '0 : r_scan_cnt;
    if (w_frame_start) begin
      case (page_mode_i)
        PAGE_HI:   w_page_next = 1'b1;
        PAGE_AUTO: begin
          if (w_fresh) begin
            w_page_next = 1'b0;
            w_scan_next = SCN_W'(1);
          end else if (r_scan_cnt == SCN_LAST) begin
            w_page_next = ~r_page;
            w_scan_next = SCN_W'(1);
          end else begin
            w_scan_next = r_scan_cnt + 1'b1;
          end
        end
        default:   w_page_next = 1'b0;
      endcase
    end
  end

  // Frame start decodes from the value being loaded so digit 0 never shows stale data.
  assign w_disp_sel = w_frame_start ? w_frame_value : r_display;
  assign w_half     = w_page_next ? w_disp_sel[31:16] : w_disp_sel[15:0];
  assign w_nibble   = w_half[{r_digit, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
  always_comb begin
    w_digit_en = 1'b1;
    case (r_digit)
      2'd1:    w_digit_en = |w_half[15:4];
      2'd2:    w_digit_en = |w_half[15:8];
      2'd3:    w_digit_en = |w_half[15:12];
      default: w_digit_en = 1'b1;
    endcase
  end
`else
  assign w_digit_en = 1'b1;
`endif

  seg7_hex_decoder u_dec (
    .nibble_i (w_nibble),
    .seg_o    (w_seg)
  );

  always_comb begin
    w_state_next = GUARD;
    w_an_next    = AN_OFF;
    if (w_cnt_next >= CNT_GUARD) w_state_next = DRIVE;
    if ((r_state == DRIVE) && !blank_i && w_digit_en) w_an_next = ~(4'b0001 << r_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= GUARD;
    else     r_state <= w_state_next;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_digit     <= 2'd0;
      r_pending   <= '0;
      r_display   <= '0;
      r_page      <= 1'b0;
      r_scan_cnt  <= '0;
      r_mode_q    <= 2'b00;
      seg_o       <= SEG_OFF;
      an_o        <= AN_OFF;
      scan_tick_o <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      if (w_cnt_wrap) r_digit <= r_digit + 2'd1;
      if (value_valid_i) r_pending <= value_i;
      if (w_frame_start) r_display <= w_frame_value;
      r_page      <= w_page_next;
      r_scan_cnt  <= w_scan_next;
      r_mode_q    <= page_mode_i;
      seg_o       <= w_seg;
      an_o        <= w_an_next;
      scan_tick_o <= (r_cnt == '0);
    end
  end

  assign page_o = r_page;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-position model pushes expected outputs
// per driven cycle; each scenario task pops and compares them after the clock edge.
module tb_seg7_scan_ctrl;

  localparam int DC = 8;
  localparam int GC = 2;
  localparam int PS = 2;
  localparam int FR = 4 * DC;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       page;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_i;
  logic        value_valid_i;
  logic [1:0]  page_mode_i;
  logic        blank_i;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        page_o;
  logic        scan_tick_o;
  exp_t        obs;

  int          n_checks = 0;
  int          n_err    = 0;
  int          pos;
  logic [31:0] m_pending, m_disp;
  logic        m_page, m_fresh;
  logic [1:0]  m_mode_prev;
  int          m_idx;
  exp_t        sb [$];

  seg7_scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC), .PAGE_SCANS(PS)) dut (
    .clk           (clk),
    .rst           (rst),
    .value_i       (value_i),
    .value_valid_i (value_valid_i),
    .page_mode_i   (page_mode_i),
    .blank_i       (blank_i),
    .seg_o         (seg_o),
    .an_o          (an_o),
    .page_o        (page_o),
    .scan_tick_o   (scan_tick_o)
  );

  always #5 clk = ~clk;
  assign obs = {seg_o, an_o, page_o, scan_tick_o};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    pos = 0; m_pending = '0; m_disp = '0; m_page = 1'b0;
    m_fresh = 1'b1; m_mode_prev = 2'b00; m_idx = 0;
  endtask

  // Expected outputs for the edge about to happen, from the inputs now applied.
  task automatic push_expected();
    exp_t e;
    logic [15:0] half;
    int cnt, dig;
    if (page_mode_i != m_mode_prev) m_fresh = 1'b1;
    m_mode_prev = page_mode_i;
    cnt = pos % DC;
    dig = (pos / DC) % 4;
    if (pos % FR == 0) begin
      m_disp = value_valid_i ? value_i : m_pending;
      case (page_mode_i)
        2'b01: m_page = 1'b1;
        2'b10: begin
          if (m_fresh) begin m_idx = 0; m_fresh = 1'b0; end
          else m_idx++;
          m_page = ((m_idx / PS) % 2) == 1;
        end
        default: m_page = 1'b0;
      endcase
    end
    if (value_valid_i) m_pending = value_i;
    half   = m_page ? m_disp[31:16] : m_disp[15:0];
    e.seg  = hex7(half[dig*4 +: 4]);
    if (cnt < GC || blank_i) e.an = 4'hF;
    else if (LZB && dig > 0 && (half >> (4 * dig)) == 16'h0) e.an = 4'hF;
    else e.an = ~(4'b0001 << dig);
    e.page = m_page;
    e.tick = (cnt == 0);
    sb.push_back(e);
  endtask

  task automatic step();
    push_expected();
    @(negedge clk);
    pos++;
  endtask

  task automatic test_reset();
    rst = 1'b1; value_valid_i = 1'b1; value_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== {7'h7F, 4'hF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", obs, {7'h7F, 4'hF, 1'b0, 1'b0});
    end
    rst = 1'b0; value_valid_i = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    exp_t e; int p, d;
    logic [3:0] an_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] sg_lit [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    value_i = 32'h0000_1234;
    for (int k = 0; k < 40; k++) begin
      value_valid_i = (k == 0);
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL basic pos=%0d got=%h exp=%h", p, obs, e); end
      if (p % DC == GC && p < FR) begin
        d = p / DC; n_checks++;
        if ({an_o, seg_o} !== {an_lit[d], sg_lit[d]})
          begin n_err++; $display("FAIL basic_digit%0d got=%h exp=%h", d, {an_o, seg_o}, {an_lit[d], sg_lit[d]}); end
      end
    end
  endtask

  task automatic test_auto_page();
    exp_t e; int p;
    logic pg_lit [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    value_valid_i = 1'b0;
    while (pos % FR != 0) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL auto_align pos=%0d got=%h exp=%h", p, obs, e); end
    end
    page_mode_i = 2'b10; value_i = 32'hABCD_1234;
    for (int k = 0; k < 5 * FR; k++) begin
      value_valid_i = (k == 0);
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL auto pos=%0d got=%h exp=%h", p, obs, e); end
      if (k % FR == 0) begin
        n_checks++;
        if (page_o !== pg_lit[k / FR])
          begin n_err++; $display("FAIL auto_page frame=%0d got=%b exp=%b", k / FR, page_o, pg_lit[k / FR]); end
      end
    end
    page_mode_i = 2'b00;
  endtask

  task automatic test_tearing();
    exp_t e; int p;
    while (pos % FR != 0) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL tear_align pos=%0d got=%h exp=%h", p, obs, e); end
    end
    for (int k = 0; k < 2 * FR; k++) begin
      value_valid_i = (k == 0) || (k == 19);
      value_i = (k < 19) ? 32'h0000_1111 : 32'h0000_5555;
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL tear pos=%0d got=%h exp=%h", p, obs, e); end
      if (k == 26 || k == FR + 2) begin
        n_checks++;
        if (seg_o !== ((k == 26) ? 7'b1111001 : 7'b0010010))
          begin n_err++; $display("FAIL tear_digit k=%0d got=%b", k, seg_o); end
      end
    end
    value_valid_i = 1'b0;
  endtask

  task automatic test_blank();
    exp_t e; int p;
    for (int k = 0; k < 60; k++) begin
      blank_i = (k >= 10 && k < 30);
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL blank pos=%0d got=%h exp=%h", p, obs, e); end
      if (k == 10) begin
        n_checks++;
        if (an_o !== 4'hF) begin n_err++; $display("FAIL blank_first got=%b exp=1111", an_o); end
      end
    end
    blank_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e; int p;
    while (pos % FR != 0) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL rmid_align pos=%0d got=%h exp=%h", p, obs, e); end
    end
    for (int k = 0; k < 2 * DC + 4; k++) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL rmid_pre pos=%0d got=%h exp=%h", p, obs, e); end
    end
    rst = 1'b1; value_valid_i = 1'b1; value_i = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (obs !== {7'h7F, 4'hF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rmid_state got=%h exp=%h", obs, {7'h7F, 4'hF, 1'b0, 1'b0});
    end
    rst = 1'b0; value_valid_i = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL rmid_post pos=%0d got=%h exp=%h", p, obs, e); end
      if (k == GC) begin
        n_checks++;
        if ({an_o, seg_o} !== {4'b1110, 7'b1000000})
          begin n_err++; $display("FAIL rmid_zero got=%h exp=%h", {an_o, seg_o}, {4'b1110, 7'b1000000}); end
      end
    end
  endtask

  task automatic test_lzb();
    exp_t e; int p;
    while (pos % FR != 0) begin
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL lzb_align pos=%0d got=%h exp=%h", p, obs, e); end
    end
    value_i = 32'h0000_0012;
    for (int k = 0; k < FR + 8; k++) begin
      value_valid_i = (k == 0);
      p = pos; step(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_err++; $display("FAIL lzb pos=%0d got=%h exp=%h", p, obs, e); end
      if (k == 2 * DC + GC || k == 3 * DC + GC) begin
        n_checks++;
        if ({an_o, seg_o} !== {(LZB ? 4'hF : ((k < 3 * DC) ? 4'b1011 : 4'b0111)), 7'b1000000})
          begin n_err++; $display("FAIL lzb_digit k=%0d got=%h", k, {an_o, seg_o}); end
      end
    end
    value_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value_i = '0; value_valid_i = 1'b0; page_mode_i = 2'b00; blank_i = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_auto_page();
    test_tearing();
    test_blank();
    test_reset_mid();
    test_lzb();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
